// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// Master drives the request side; slave (the adder) drives results.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin,
        input  ready, busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output ready, busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, one bit per clock.
// IDLE -> RUN (WIDTH bits) -> DONE (one-cycle result pulse) -> IDLE.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    serial_adder_if.slave s_bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic             r_cmsb;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic             w_accept;
    logic             w_ready;
    logic             w_busy;
    logic             w_done;

    // Single full-adder cell working on the current LSBs.
    assign w_s      = r_a[0] ^ r_b[0] ^ r_c;
    assign w_c      = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_accept = (r_state == IDLE) && s_bus.start;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and status decode.
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (s_bus.start) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operand load on acceptance, then one shift/add step per RUN cycle.
    // cout and the MSB carry-in only move on the last bit, so they keep
    // the previous result visible while the next sum is being shifted in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_sum  <= '0;
            r_c    <= 1'b0;
            r_cmsb <= 1'b0;
            r_cout <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_a   <= s_bus.a;
            r_b   <= s_bus.b;
            r_c   <= s_bus.cin;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_sum <= {w_s, r_sum[WIDTH-1:1]};
            r_c   <= w_c;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_cmsb <= r_c;
                r_cout <= w_c;
            end
        end
    end

    assign s_bus.ready = w_ready;
    assign s_bus.busy  = w_busy;
    assign s_bus.done  = w_done;
    assign s_bus.sum   = r_sum;
    assign s_bus.cout  = r_cout;
    assign s_bus.ovf   = r_cmsb ^ r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 and WIDTH=2 instances, random and
// directed operations checked against an arithmetic reference model.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(2)) if2 ();

    serial_adder #(.WIDTH(8)) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .s_bus (if8)
    );

    serial_adder #(.WIDTH(2)) u2 (
        .clk   (clk),
        .rst_n (rst_n),
        .s_bus (if2)
    );

    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        ov;
        int          due;
    } op_t;

    op_t         q0[$];
    op_t         q1[$];
    int          total = 0;
    int          bad = 0;
    int          ecnt = 0;
    logic [31:0] ls[2];
    logic        lco[2];
    logic        lov[2];
    bit          hold2 = 1'b0;
    int          prev_done2 = -1;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
        end
    endtask

    task automatic flag(input string nm);
        total++;
        bad++;
        $display("FAIL %s", nm);
    endtask

    // Reference: plain integer addition of the masked operands.
    function automatic op_t model(input int w, input logic [31:0] a,
                                  input logic [31:0] b, input logic c,
                                  input int due);
        op_t             r;
        longint unsigned m;
        longint unsigned full;
        m = (64'd1 << w) - 64'd1;
        full = ({32'd0, a} & m) + ({32'd0, b} & m) + {63'd0, c};
        r.s = 32'(full & m);
        r.co = full[w];
        r.ov = (a[w-1] == b[w-1]) && (r.s[w-1] != a[w-1]);
        r.due = due;
        return r;
    endfunction

    // Per-cycle comparison of one DUT against the model queue.
    task automatic cyc(input int d, input int w, input logic rdy,
                       input logic bsy, input logic dn,
                       input logic [31:0] s, input logic co,
                       input logic ov, input logic st,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic c);
        op_t   e;
        int    n;
        string p;
        p = (d == 0) ? "w8" : "w2";
        n = (d == 0) ? q0.size() : q1.size();
        if (!rst_n) begin
            if (d == 0) q0.delete();
            else q1.delete();
            ls[d] = '0;
            lco[d] = 1'b0;
            lov[d] = 1'b0;
            if (d == 1) prev_done2 = -1;
            chk({p, ".rst_ready"}, 32'(rdy), 1);
            chk({p, ".rst_busy"}, 32'(bsy), 0);
            chk({p, ".rst_done"}, 32'(dn), 0);
            chk({p, ".rst_sum"}, s, 0);
            chk({p, ".rst_cout"}, 32'(co), 0);
            chk({p, ".rst_ovf"}, 32'(ov), 0);
            return;
        end
        chk({p, ".onehot"}, 32'(rdy) + 32'(bsy) + 32'(dn), 1);
        if (dn) begin
            if (n == 0) begin
                flag({p, ".unexpected_done"});
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk({p, ".latency"}, ecnt, e.due);
                chk({p, ".sum"}, s, e.s);
                chk({p, ".cout"}, 32'(co), 32'(e.co));
                chk({p, ".ovf"}, 32'(ov), 32'(e.ov));
                ls[d] = e.s;
                lco[d] = e.co;
                lov[d] = e.ov;
            end
            if (d == 1 && hold2) begin
                if (prev_done2 >= 0)
                    chk("w2.period", ecnt - prev_done2, 4);
                prev_done2 = ecnt;
            end
        end else if (n > 0) begin
            e = (d == 0) ? q0[0] : q1[0];
            if (ecnt >= e.due) begin
                flag({p, ".missing_done"});
                if (d == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
            end
        end
        if (bsy) begin
            chk({p, ".run_cout_hold"}, 32'(co), 32'(lco[d]));
            chk({p, ".run_ovf_hold"}, 32'(ov), 32'(lov[d]));
        end
        if (rdy) begin
            chk({p, ".idle_sum_hold"}, s, ls[d]);
            chk({p, ".idle_cout_hold"}, 32'(co), 32'(lco[d]));
            chk({p, ".idle_ovf_hold"}, 32'(ov), 32'(lov[d]));
            if (st) begin
                if (d == 0) q0.push_back(model(w, a, b, c, ecnt + 1 + w));
                else q1.push_back(model(w, a, b, c, ecnt + 1 + w));
            end
        end
    endtask

    always @(negedge clk)
        cyc(0, 8, if8.ready, if8.busy, if8.done, 32'(if8.sum), if8.cout,
            if8.ovf, if8.start, 32'(if8.a), 32'(if8.b), if8.cin);

    always @(negedge clk)
        cyc(1, 2, if2.ready, if2.busy, if2.done, 32'(if2.sum), if2.cout,
            if2.ovf, if2.start, 32'(if2.a), 32'(if2.b), if2.cin);

    // Directed WIDTH=8 operation with literal expectations.
    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic c, input bit mid,
                       input logic [7:0] es, input logic eco,
                       input logic eov, input string nm);
        int n;
        bit seen;
        @(posedge clk);
        #1;
        if8.a = a;
        if8.b = b;
        if8.cin = c;
        if8.start = 1'b1;
        @(posedge clk);
        n = 1;
        #1;
        if8.start = 1'b0;
        if8.a = 8'($urandom);
        if8.b = 8'($urandom);
        if8.cin = 1'($urandom_range(0, 1));
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            if (if8.done) begin
                seen = 1'b1;
            end else begin
                if (mid) chk({nm, ".busy"}, 32'(if8.busy), 1);
                @(posedge clk);
                n++;
                #1;
                if (mid) begin
                    if8.start = (n == 4);
                    if (n == 4) begin
                        if8.a = 8'h01;
                        if8.b = 8'h01;
                    end
                end
            end
        end
        if8.start = 1'b0;
        if (!seen) begin
            flag({nm, ".timeout"});
        end else begin
            chk({nm, ".edges"}, n, 9);
            chk({nm, ".sum"}, 32'(if8.sum), 32'(es));
            chk({nm, ".cout"}, 32'(if8.cout), 32'(eco));
            chk({nm, ".ovf"}, 32'(if8.ovf), 32'(eov));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        op_t m;
        int  k;
        if8.start = 1'b0;
        if8.a = '0;
        if8.b = '0;
        if8.cin = 1'b0;
        if2.start = 1'b0;
        if2.a = '0;
        if2.b = '0;
        if2.cin = 1'b0;

        m = model(8, 32'h0F, 32'h01, 1'b0, 0);
        chk("model.0f01_sum", m.s, 32'h10);
        m = model(8, 32'hFF, 32'h01, 1'b0, 0);
        chk("model.ff01_cout", 32'(m.co), 1);
        m = model(8, 32'h7F, 32'h00, 1'b1, 0);
        chk("model.7f_ovf", 32'(m.ov), 1);
        m = model(2, 32'h3, 32'h3, 1'b1, 0);
        chk("model.w2_sum", m.s, 32'h3);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        op8(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, "r029");
        op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "r030a");
        op8(8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, "r030b");
        op8(8'h55, 8'hAA, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, "r031");

        @(posedge clk);
        #1;
        if8.a = 8'h12;
        if8.b = 8'h34;
        if8.cin = 1'b0;
        if8.start = 1'b1;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort.busy", 32'(if8.busy), 0);
        chk("abort.ready", 32'(if8.ready), 1);
        chk("abort.done", 32'(if8.done), 0);
        chk("abort.sum", 32'(if8.sum), 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort.no_done", 32'(if8.done), 0);
        end
        op8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, "r032");

        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if8.a = 8'($urandom);
            if8.b = 8'($urandom);
            if8.cin = 1'($urandom_range(0, 1));
            if8.start = 1'b1;
            @(negedge clk);
            k = 0;
            while (!if8.ready && k < 30) begin
                @(negedge clk);
                k++;
            end
            if (k >= 30) flag("rand.accept_timeout");
            @(posedge clk);
            #1;
            if8.start = 1'b0;
            if8.a = 8'($urandom);
            if8.b = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        repeat (12) @(posedge clk);

        #1;
        hold2 = 1'b1;
        if2.start = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if2.a = 2'(i >> 3);
            if2.b = 2'(i >> 1);
            if2.cin = 1'(i);
            @(negedge clk);
            k = 0;
            while (!if2.ready && k < 10) begin
                @(negedge clk);
                k++;
            end
            if (k >= 10) flag("w2.accept_timeout");
            @(posedge clk);
            #1;
        end
        if2.start = 1'b0;
        repeat (8) @(posedge clk);
        chk("w2.queue_empty", q1.size(), 0);
        chk("w8.queue_empty", q0.size(), 0);
        hold2 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition; sampled only while ready=1.
REQ-005 The block SHALL have port a, input, WIDTH bits: operand A; sampled on the accepting edge only.
REQ-006 The block SHALL have port b, input, WIDTH bits: operand B; sampled on the accepting edge only.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in; sampled on the accepting edge only.
REQ-008 The block SHALL have port ready, output, 1 bit: high only in IDLE.
REQ-009 The block SHALL have port busy, output, 1 bit: high only in RUN.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-011 The block SHALL have port sum, output, WIDTH bits: result of a+b+cin modulo 2^WIDTH.
REQ-012 The block SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1.
REQ-013 The block SHALL have port ovf, output, 1 bit: two's-complement overflow, equal to (carry into bit WIDTH-1) XOR cout.

Function
REQ-014 The block SHALL compute the sum bit-serially, LSB first, with one full-adder cell and one carry register, processing one bit per clock.
REQ-015 The block SHALL implement a state machine with exactly three states: IDLE, RUN and DONE.
REQ-016 The state machine SHALL have exactly these transitions: IDLE->RUN on start=1; RUN->DONE after WIDTH bit-cycles; DONE->IDLE unconditionally.
REQ-017 On the accepting edge E0 (IDLE with start=1), the block SHALL:
- load a and b into shift registers;
- load cin into the carry register;
- clear the bit counter.
REQ-018 At each of edges E1..EW in RUN, the block SHALL:
- add the LSBs of the A and B shift registers with the carry;
- shift the sum bit into sum from the MSB side;
- update the carry register;
- increment the counter.
REQ-019 At edge EW the block SHALL capture the carry into bit WIDTH-1 for the ovf computation.
REQ-020 done SHALL be high for exactly the one cycle following EW (state DONE), i.e. latency is WIDTH+1 edges from start acceptance to done.
REQ-021 sum, cout and ovf SHALL be valid while done=1 and SHALL hold their values until the next accepting edge.
REQ-022 During RUN, sum is the partial shift state and SHALL NOT be considered valid; cout and ovf SHALL hold their previous result.
REQ-023 start SHALL be ignored in RUN and DONE, and a, b and cin changes after E0 SHALL NOT affect the result.
REQ-024 A start held high continuously SHALL begin a new operation on each return to IDLE, giving throughput of one result per WIDTH+2 cycles.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide, and SHALL NOT wrap within an operation.

Reset
REQ-026 While rst_n=0, the block SHALL, immediately and independent of clk:
- enter IDLE;
- drive ready=1, busy=0, done=0;
- drive sum=0, cout=0, ovf=0;
- clear the carry register, counter and shift registers.
REQ-027 An assertion of rst_n during RUN or DONE SHALL abort the operation with no done pulse, and the aborted result SHALL never appear.
REQ-028 The first accepting edge SHALL be the first rising clk edge after rst_n deasserts with start=1.

Verification
REQ-029 With WIDTH=8, the bench SHALL apply a=0x0F, b=0x01, cin=0 -> done exactly 9 edges after acceptance, sum=0x10, cout=0, ovf=0.
REQ-030 With WIDTH=8, the bench SHALL apply a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; then a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
REQ-031 With WIDTH=8, the bench SHALL run a=0x55, b=0xAA, cin=1, pulse start=1 with a=0x01, b=0x01 mid-RUN -> start ignored, sum=0x00, cout=1, and busy stays high throughout RUN.
REQ-032 With WIDTH=8, the bench SHALL pull rst_n low at RUN bit 4 of a=0x12, b=0x34 -> busy=0, ready=1, sum=0x00 immediately, no done; the next operation 0x12+0x34 -> sum=0x46.
REQ-033 With WIDTH=2, the bench SHALL run all 32 combinations of a, b and cin with start held high -> every result matches a+b+cin, and done pulses recur every 4 cycles.
